// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit: decodes opcode/funct into datapath
// enables and mux selects, with memory wait, illegal-instruction trap and a
// retired-instruction counter.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned TRAP_RECOVER  = 0,
  parameter int unsigned RTYPE_EN      = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [5:0]       i_op,
  input  logic [5:0]       i_funct,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_en,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             o_branch_ne,
  output logic [1:0]       IorD,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       RegDst,
  output logic [2:0]       ALUOp,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired,
  output logic [7:0]       cur_state,
  output logic [7:0]       nxt_state
);

  typedef enum logic [7:0] {
    FETCH     = 8'd0,
    DECODE    = 8'd1,
    MEM_ADR   = 8'd2,
    MEM_READ  = 8'd3,
    MEM_WB    = 8'd4,
    MEM_WRITE = 8'd5,
    ADDI_WB   = 8'd6,
    EXECUTE   = 8'd7,
    ALU_WB    = 8'd8,
    BRANCH    = 8'd9,
    JUMP      = 8'd12,
    JAL       = 8'd13,
    TRAP      = 8'd255
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_NOP = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t state_q;
  state_t state_d;
  logic   rdy;
  logic   funct_ok;
  logic   retire_c;

  // Memory ready, forced high when the handshake is disabled
  assign rdy = (MEM_HANDSHAKE != 0) ? i_mem_ready : 1'b1;

  // Supported R-type functs
  assign funct_ok = (i_funct == FN_ADD) || (i_funct == FN_SUB) ||
                    (i_funct == FN_AND) || (i_funct == FN_OR)  ||
                    (i_funct == FN_SLT);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // Next-state and control outputs
  always_comb begin
    state_d     = FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    o_branch_ne = 1'b0;
    IorD        = 2'd0;
    MemtoReg    = 2'd0;
    PCSource    = 2'd0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    RegDst      = 2'd0;
    ALUOp       = 3'd0;
    o_illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        IRWrite = rdy;
        PCWrite = rdy;
        state_d = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        case (i_op)
          OP_RTYPE: begin
            if (i_funct == FN_NOP)                 state_d = FETCH;
            else if ((RTYPE_EN != 0) && funct_ok)  state_d = EXECUTE;
            else                                   state_d = TRAP;
          end
          OP_J:                   state_d = JUMP;
          OP_JAL:                 state_d = JAL;
          OP_BEQ, OP_BNE:         state_d = BRANCH;
          OP_ADDI, OP_LW, OP_SW:  state_d = MEM_ADR;
          default:                state_d = TRAP;
        endcase
      end
      MEM_ADR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        case (i_op)
          OP_LW:   state_d = MEM_READ;
          OP_SW:   state_d = MEM_WRITE;
          OP_ADDI: state_d = ADDI_WB;
          default: state_d = TRAP;
        endcase
      end
      MEM_READ: begin
        IorD    = 2'd1;
        MemRead = 1'b1;
        state_d = rdy ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        MemtoReg = 2'd1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      MEM_WRITE: begin
        IorD     = 2'd1;
        MemWrite = 1'b1;
        state_d  = rdy ? FETCH : MEM_WRITE;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      EXECUTE: begin
        ALUSrcA = 2'd1;
        ALUOp   = 3'd2;
        state_d = ALU_WB;
      end
      ALU_WB: begin
        RegDst   = 2'd1;
        RegWrite = 1'b1;
        state_d  = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 2'd1;
        ALUOp       = 3'd1;
        PCSource    = 2'd1;
        PCWriteCond = 1'b1;
        o_branch_ne = (i_op == OP_BNE);
        state_d     = FETCH;
      end
      JUMP: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
        state_d  = FETCH;
      end
      JAL: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        RegDst   = 2'd2;
        MemtoReg = 2'd2;
        state_d  = FETCH;
      end
      TRAP: begin
        o_illegal = 1'b1;
        state_d   = (TRAP_RECOVER != 0) ? FETCH : TRAP;
      end
      default: state_d = FETCH;
    endcase
  end

  // Combined PC enable for unconditional and taken conditional writes
  assign o_pc_en = PCWrite | (PCWriteCond & (i_zero ^ o_branch_ne));

  // An instruction retires on any return to FETCH except from FETCH or TRAP
  assign retire_c = (state_q != FETCH) && (state_q != TRAP) && (state_d == FETCH);

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      o_retired <= '0;
    else if (retire_c) o_retired <= o_retired + CNT_W'(1);
  end

  assign cur_state = state_q;
  assign nxt_state = state_d;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: three configurations share one stimulus
// stream and are each compared every cycle against an instruction-path model.
module tb_multicycle_ctrl_fsm;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [5:0] i_op = 6'd0;
  logic [5:0] i_funct = 6'd0;
  logic       i_zero = 1'b0;
  logic       i_mem_ready = 1'b0;

  always #5 i_clk = ~i_clk;

  // Configurations: 0 default, 1 trap-recover without R-type, 2 no handshake with 2-bit counter
  localparam int P_HS[3]  = '{1, 1, 0};
  localparam int P_REC[3] = '{0, 1, 0};
  localparam int P_RT[3]  = '{1, 0, 1};
  localparam int P_CW[3]  = '{16, 16, 2};

  logic       pc_en[3], pcw[3], pcwc[3], irw[3], mr[3], mw[3], rw[3], bne[3], ill[3];
  logic [1:0] iord[3], m2r[3], pcs[3], asa[3], asb[3], rd[3];
  logic [2:0] aop[3];
  logic [7:0] dst[3], dnx[3];
  logic [15:0] ret[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] r;
    multicycle_ctrl_fsm #(
      .MEM_HANDSHAKE((g == 2) ? 0 : 1),
      .TRAP_RECOVER ((g == 1) ? 1 : 0),
      .RTYPE_EN     ((g == 1) ? 0 : 1),
      .CNT_W        (CW)
    ) u_dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_op(i_op), .i_funct(i_funct),
      .i_zero(i_zero), .i_mem_ready(i_mem_ready),
      .o_pc_en(pc_en[g]), .PCWrite(pcw[g]), .PCWriteCond(pcwc[g]),
      .IRWrite(irw[g]), .MemRead(mr[g]), .MemWrite(mw[g]), .RegWrite(rw[g]),
      .o_branch_ne(bne[g]), .IorD(iord[g]), .MemtoReg(m2r[g]),
      .PCSource(pcs[g]), .ALUSrcA(asa[g]), .ALUSrcB(asb[g]), .RegDst(rd[g]),
      .ALUOp(aop[g]), .o_illegal(ill[g]), .o_retired(r),
      .cur_state(dst[g]), .nxt_state(dnx[g])
    );
    assign ret[g] = 16'(r);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic pcw, pcwc, irw, mr, mw, rw, bne, ill, pcen;
    logic [1:0] iord, m2r, pcs, asa, asb, rd;
    logic [2:0] aop;
  } ctl_t;

  // ---------------- model: each instruction is a path of states ----------------
  int m_st[3]  = '{0, 0, 0};
  int m_ret[3] = '{0, 0, 0};
  int m_op[3]  = '{0, 0, 0};
  int m_fn[3]  = '{0, 0, 0};
  int m_pos[3] = '{0, 0, 0};

  // k-th state after DECODE for an instruction; 0 means back to FETCH
  function automatic int path_at(input int op, input int fn, input int rt, input int k);
    int seq[4];
    seq = '{0, 0, 0, 0};
    case (op)
      0: begin
        if (fn == 0) seq[0] = 0;
        else if (rt != 0 && (fn == 32 || fn == 34 || fn == 36 || fn == 37 || fn == 42)) begin
          seq[0] = 7; seq[1] = 8;
        end else seq[0] = 255;
      end
      2:      seq[0] = 12;
      3:      seq[0] = 13;
      4, 5:   seq[0] = 9;
      35:     begin seq[0] = 2; seq[1] = 3; seq[2] = 4; end
      43:     begin seq[0] = 2; seq[1] = 5; end
      8:      begin seq[0] = 2; seq[1] = 6; end
      default: seq[0] = 255;
    endcase
    return (k < 4) ? seq[k] : 0;
  endfunction

  function automatic int m_rdy(input int i);
    return (P_HS[i] != 0) ? int'(i_mem_ready) : 1;
  endfunction

  function automatic int pred(input int i);
    int st;
    st = m_st[i];
    if (st == 0)   return (m_rdy(i) != 0) ? 1 : 0;
    if (st == 1)   return path_at(int'(i_op), int'(i_funct), P_RT[i], 0);
    if (st == 255) return (P_REC[i] != 0) ? 0 : 255;
    if ((st == 3 || st == 5) && m_rdy(i) == 0) return st;
    return path_at(m_op[i], m_fn[i], P_RT[i], m_pos[i]);
  endfunction

  function automatic ctl_t exp_ctl(input int i);
    ctl_t c;
    logic r;
    c = '0;
    r = (m_rdy(i) != 0);
    case (m_st[i])
      0:   begin c.mr = 1; c.asb = 1; c.irw = r; c.pcw = r; end
      1:   c.asb = 3;
      2:   begin c.asa = 1; c.asb = 2; end
      3:   begin c.iord = 1; c.mr = 1; end
      4:   begin c.m2r = 1; c.rw = 1; end
      5:   begin c.iord = 1; c.mw = 1; end
      6:   c.rw = 1;
      7:   begin c.asa = 1; c.aop = 2; end
      8:   begin c.rd = 1; c.rw = 1; end
      9:   begin c.asa = 1; c.aop = 1; c.pcs = 1; c.pcwc = 1; c.bne = (i_op == 6'd5); end
      12:  begin c.pcs = 2; c.pcw = 1; end
      13:  begin c.pcs = 2; c.pcw = 1; c.rw = 1; c.rd = 2; c.m2r = 2; end
      255: c.ill = 1;
      default: c = '0;
    endcase
    c.pcen = c.pcw | (c.pcwc & (i_zero ^ c.bne));
    return c;
  endfunction

  function automatic ctl_t dut_ctl(input int i);
    ctl_t c;
    c.pcw = pcw[i]; c.pcwc = pcwc[i]; c.irw = irw[i]; c.mr = mr[i]; c.mw = mw[i];
    c.rw = rw[i]; c.bne = bne[i]; c.ill = ill[i]; c.pcen = pc_en[i];
    c.iord = iord[i]; c.m2r = m2r[i]; c.pcs = pcs[i]; c.asa = asa[i];
    c.asb = asb[i]; c.rd = rd[i]; c.aop = aop[i];
    return c;
  endfunction

  // Model advance
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_st[i] <= 0; m_ret[i] <= 0; m_pos[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int n;
        n = pred(i);
        if (n == 0 && m_st[i] != 0 && m_st[i] != 255)
          m_ret[i] <= (m_ret[i] + 1) % (1 << P_CW[i]);
        if (m_st[i] == 1) begin
          m_op[i] <= int'(i_op); m_fn[i] <= int'(i_funct); m_pos[i] <= 1;
        end else if (n != m_st[i]) m_pos[i] <= m_pos[i] + 1;
        m_st[i] <= n;
      end
    end
  end

  // Per-cycle comparison of all instances against the model
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cyc_state%0d", i),   longint'(dst[i]), longint'(m_st[i]));
        chk($sformatf("cyc_next%0d", i),    longint'(dnx[i]), longint'(pred(i)));
        chk($sformatf("cyc_ctl%0d", i),     longint'(dut_ctl(i)), longint'(exp_ctl(i)));
        chk($sformatf("cyc_retired%0d", i), longint'(ret[i]), longint'(m_ret[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic adv;
    @(posedge i_clk); #1;
  endtask

  task automatic settle;
    @(negedge i_clk); #1;
  endtask

  task automatic reset_dut;
    i_rst_n = 1'b0;
    adv; adv;
    i_rst_n = 1'b1;
  endtask

  int lw_st[11]  = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 0};
  int lw_rdy[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
  int irw_n;
  int rw_n;

  initial begin
    // Reset values
    reset_dut;
    settle;
    chk("rst_state",   dst[0], 0);
    chk("rst_memread", mr[0], 1);
    chk("rst_alusrcb", asb[0], 1);
    chk("rst_irwrite", irw[0], 0);
    chk("rst_retired", ret[0], 0);

    // lw with memory waits
    reset_dut;
    i_op = 6'd35; i_funct = 6'd0;
    irw_n = 0; rw_n = 0;
    for (int i = 0; i < 11; i++) begin
      i_mem_ready = lw_rdy[i][0];
      settle;
      chk($sformatf("lw_state%0d", i), dst[0], lw_st[i]);
      if (irw[0]) irw_n++;
      if (rw[0]) begin
        rw_n++;
        chk("lw_rw_in_memwb", dst[0], 4);
      end
      adv;
    end
    chk("lw_irwrite_pulses", irw_n, 1);
    chk("lw_regwrite_cycles", rw_n, 1);
    chk("lw_retired", ret[0], 1);

    // beq taken, then bne not taken, both with zero=1
    reset_dut;
    i_mem_ready = 1'b1; i_zero = 1'b1; i_op = 6'd4;
    for (int i = 0; i < 3; i++) begin
      settle;
      if (i == 2) begin
        chk("beq_state", dst[0], 9);
        chk("beq_pc_en", pc_en[0], 1);
        chk("beq_bne", bne[0], 0);
      end
      adv;
    end
    i_op = 6'd5;
    for (int i = 0; i < 3; i++) begin
      settle;
      if (i == 2) begin
        chk("bne_state", dst[0], 9);
        chk("bne_pc_en", pc_en[0], 0);
        chk("bne_bne", bne[0], 1);
      end
      adv;
    end
    settle;
    chk("br_retired", ret[0], 2);
    i_zero = 1'b0;

    // jal
    reset_dut;
    i_op = 6'd3;
    for (int i = 0; i < 4; i++) begin
      settle;
      if (i == 2) begin
        chk("jal_state", dst[0], 13);
        chk("jal_pcwrite", pcw[0], 1);
        chk("jal_regwrite", rw[0], 1);
        chk("jal_regdst", rd[0], 2);
        chk("jal_memtoreg", m2r[0], 2);
        chk("jal_pcsource", pcs[0], 2);
      end
      if (i == 3) chk("jal_back_fetch", dst[0], 0);
      adv;
    end

    // R-type add; the R-type-disabled instance traps instead
    reset_dut;
    i_op = 6'd0; i_funct = 6'h20;
    for (int i = 0; i < 5; i++) begin
      settle;
      if (i == 2) begin
        chk("add_state", dst[0], 7);
        chk("add_aluop", aop[0], 2);
        chk("add_nort_state", dst[1], 255);
        chk("add_nort_illegal", ill[1], 1);
      end
      if (i == 3) begin
        chk("add_wb_state", dst[0], 8);
        chk("add_wb_regdst", rd[0], 1);
      end
      if (i == 4) chk("add_retired", ret[0], 1);
      adv;
    end

    // Unsupported funct: sticky trap
    reset_dut;
    i_funct = 6'h01;
    for (int i = 0; i < 12; i++) begin
      settle;
      if (i >= 2) chk($sformatf("trap_hold%0d", i), ill[0], 1);
      adv;
    end
    chk("trap_sticky_state", dst[0], 255);
    chk("trap_retired", ret[0], 0);

    // Recovering trap after one retired NOP
    reset_dut;
    i_op = 6'd0; i_funct = 6'd0;
    adv; adv;
    i_op = 6'h3F;
    for (int i = 0; i < 4; i++) begin
      settle;
      if (i == 2) begin
        chk("rec_trap_state", dst[1], 255);
        chk("rec_trap_illegal", ill[1], 1);
      end
      if (i == 3) begin
        chk("rec_fetch_state", dst[1], 0);
        chk("rec_retired", ret[1], 1);
      end
      adv;
    end

    // NOPs on the 2-bit counter: 1, 2, 3, 0
    reset_dut;
    i_op = 6'd0; i_funct = 6'd0;
    for (int k = 0; k < 4; k++) begin
      adv; adv;
      settle;
      chk($sformatf("nop_wrap%0d", k), ret[2], (k + 1) % 4);
    end

    // Reset asserted during a waiting MEM_WRITE
    reset_dut;
    i_op = 6'd0; i_funct = 6'd0; i_mem_ready = 1'b1;
    adv; adv;
    i_op = 6'd43;
    adv; adv; adv;
    i_mem_ready = 1'b0;
    settle;
    chk("sw_state", dst[0], 5);
    chk("sw_memwrite", mw[0], 1);
    chk("sw_pre_retired", ret[0], 1);
    i_rst_n = 1'b0;
    #1;
    chk("sw_rst_memwrite", mw[0], 0);
    chk("sw_rst_state", dst[0], 0);
    chk("sw_rst_retired", ret[0], 0);
    adv;
    i_rst_n = 1'b1;
    settle;
    chk("sw_post_memwrite", mw[0], 0);
    chk("sw_post_state", dst[0], 0);
    adv;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
